// File: rtl/nco_hop_ctrl.sv
// nco_hop_ctrl: phase-increment hop sequencer for the OFDM carrier NCO.
// Steps the NCO through a small table of phase increments. For each slot it
// waits out the NCO pipeline latency and then qualifies "dwell" valid samples.
// Optional build macro NCO_HOP_LOOP_EN: wrap back to slot 0 after the last slot
// and keep looping until stop, pulsing done once per completed pass.
module nco_hop_ctrl #(
    parameter int apr     = 32,
    parameter int nslots  = 8,
    parameter int slot_aw = 3,
    parameter int dwr     = 16,
    parameter int lat     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [slot_aw-1:0] cfg_addr,
    input  logic [apr-1:0]     cfg_data,
    input  logic [slot_aw-1:0] cfg_last,
    input  logic [dwr-1:0]     dwell,
    input  logic               start,
    input  logic               stop,
    input  logic               nco_valid,
    output logic [apr-1:0]     phi_inc_o,
    output logic               nco_clken,
    output logic               sample_en,
    output logic               slot_first,
    output logic [slot_aw-1:0] slot_idx,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

    // Table is sized to the full address space so every index is in range;
    // only entries below nslots are ever written or read.
    localparam int                 tbl_depth   = 1 << slot_aw;
    localparam logic [7:0]         settle_init = 8'(lat - 1);
    localparam logic [slot_aw-1:0] last_max    = slot_aw'(nslots - 1);

    state_t             state;
    logic [apr-1:0]     tbl [tbl_depth];
    logic [7:0]         settle_cnt;
    logic [dwr-1:0]     dwell_cnt;
    logic [dwr-1:0]     dwell_l;
    logic [slot_aw-1:0] last_l;
    logic               first_flag;
    logic [slot_aw-1:0] next_idx;

    assign next_idx   = slot_idx + slot_aw'(1);
    assign nco_clken  = busy;
    assign sample_en  = (state == RUN) && nco_valid;
    assign slot_first = sample_en && first_flag;

    // Configuration writes to the increment table, accepted only while idle.
    always_ff @(posedge clk) begin
        if (state == IDLE && !busy && cfg_we && (int'(cfg_addr) < nslots)) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

    // Slot sequencer: IDLE -> SETTLE (pipeline flush) -> RUN (dwell samples).
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            phi_inc_o  <= '0;
            slot_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            settle_cnt <= '0;
            dwell_cnt  <= '0;
            dwell_l    <= '0;
            last_l     <= '0;
            first_flag <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                // Abort: no done pulse, increment left as is.
                state    <= IDLE;
                busy     <= 1'b0;
                slot_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            last_l     <= (cfg_last > last_max) ? last_max : cfg_last;
                            dwell_l    <= (dwell == '0) ? dwr'(1) : dwell;
                            phi_inc_o  <= tbl[0];
                            slot_idx   <= '0;
                            settle_cnt <= settle_init;
                            busy       <= 1'b1;
                            state      <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        // Hold here after the count expires until the NCO reports valid.
                        if (settle_cnt != '0) begin
                            settle_cnt <= settle_cnt - 8'd1;
                        end else if (nco_valid) begin
                            dwell_cnt  <= dwell_l - dwr'(1);
                            first_flag <= 1'b1;
                            state      <= RUN;
                        end
                    end
                    RUN: begin
                        if (sample_en) begin
                            first_flag <= 1'b0;
                            if (dwell_cnt != '0) begin
                                dwell_cnt <= dwell_cnt - dwr'(1);
                            end else if (slot_idx != last_l) begin
                                slot_idx   <= next_idx;
                                phi_inc_o  <= tbl[next_idx];
                                settle_cnt <= settle_init;
                                state      <= SETTLE;
                            end else begin
`ifdef NCO_HOP_LOOP_EN
                                slot_idx   <= '0;
                                phi_inc_o  <= tbl[0];
                                settle_cnt <= settle_init;
                                state      <= SETTLE;
                                done       <= 1'b1;
`else
                                state      <= IDLE;
                                busy       <= 1'b0;
                                done       <= 1'b1;
`endif
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nco_hop_ctrl.sv
// tb_nco_hop_ctrl: directed self-checking bench for nco_hop_ctrl.
// Cycle index c counts clock edges after the start edge (c=0 is the first
// cycle after start is taken). With lat=8 and nco_valid=1 the first sample
// shows at c=8, and each slot occupies lat+dwell cycles.
module tb_nco_hop_ctrl;

    localparam int APR = 32;
    localparam int NS  = 8;
    localparam int SAW = 4;
    localparam int DWR = 16;
    localparam int LAT = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           cfg_we = 1'b0;
    logic [SAW-1:0] cfg_addr = '0;
    logic [APR-1:0] cfg_data = '0;
    logic [SAW-1:0] cfg_last = '0;
    logic [DWR-1:0] dwell = '0;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic           nco_valid = 1'b0;
    logic [APR-1:0] phi_inc_o;
    logic           nco_clken;
    logic           sample_en;
    logic           slot_first;
    logic [SAW-1:0] slot_idx;
    logic           busy;
    logic           done;

    int n_chk = 0;
    int n_fail = 0;

    // Per-pass observations filled in by run_pass
    int             n_samp, first_c, done_c, n_done, n_first;
    int             first_num [4];
    logic [APR-1:0] phi_log [80];
    logic           busy_log [80];
    logic [SAW-1:0] idx_log [80];

    nco_hop_ctrl #(.apr(APR), .nslots(NS), .slot_aw(SAW), .dwr(DWR), .lat(LAT)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_last(cfg_last), .dwell(dwell), .start(start),
        .stop(stop), .nco_valid(nco_valid), .phi_inc_o(phi_inc_o),
        .nco_clken(nco_clken), .sample_en(sample_en), .slot_first(slot_first),
        .slot_idx(slot_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [SAW-1:0] a, input logic [APR-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    // Start a pass and observe ncyc cycles; nco_valid goes high at c>=valid_on,
    // stop is pulsed in cycle stop_at (negative = never).
    task automatic run_pass(input int valid_on, input int stop_at, input int ncyc);
        n_samp = 0; first_c = -1; done_c = -1; n_done = 0; n_first = 0;
        for (int i = 0; i < 4; i++) first_num[i] = 0;
        nco_valid = (valid_on <= 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            nco_valid = (c >= valid_on);
            stop = (c == stop_at);
            #1;
            phi_log[c] = phi_inc_o; busy_log[c] = busy; idx_log[c] = slot_idx;
            if (sample_en) begin
                n_samp++;
                if (first_c < 0) first_c = c;
            end
            if (slot_first) begin
                if (n_first < 4) first_num[n_first] = n_samp;
                n_first++;
            end
            if (done) begin
                n_done++;
                if (done_c < 0) done_c = c;
            end
            tick();
        end
        stop = 1'b0;
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        check("rst_phi", phi_inc_o, 0);
        check("rst_idx", slot_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_clken", nco_clken, 0);

        wr(0, 32'h0100_0000);
        wr(1, 32'h0200_0000);
        wr(2, 32'h0300_0000);

`ifdef NCO_HOP_LOOP_EN
        // Looping: 2 slots x (8+2) cycles, done every 20 cycles, busy held.
        cfg_last = 1; dwell = 2;
        run_pass(0, -1, 50);
        check("loop_idx10", idx_log[10], 1);
        check("loop_idx20", idx_log[20], 0);
        check("loop_idx30", idx_log[30], 1);
        check("loop_phi20", phi_log[20], 32'h0100_0000);
        check("loop_done_c", done_c, 20);
        check("loop_n_done", n_done, 2);
        check("loop_busy", busy_log[45], 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("loop_stop_busy", busy, 0);
`else
        // Three-slot pass
        cfg_last = 2; dwell = 4;
        run_pass(0, -1, 40);
        check("p1_clken", dut.nco_clken, 0);
        check("p1_phi0", phi_log[0], 32'h0100_0000);
        check("p1_busy0", busy_log[0], 1);
        check("p1_phi11", phi_log[11], 32'h0100_0000);
        check("p1_phi12", phi_log[12], 32'h0200_0000);
        check("p1_phi24", phi_log[24], 32'h0300_0000);
        check("p1_idx24", idx_log[24], 2);
        check("p1_first_c", first_c, 8);
        check("p1_n_samp", n_samp, 12);
        check("p1_n_first", n_first, 3);
        check("p1_first1", first_num[0], 1);
        check("p1_first2", first_num[1], 5);
        check("p1_first3", first_num[2], 9);
        check("p1_done_c", done_c, 36);
        check("p1_n_done", n_done, 1);
        check("p1_busy35", busy_log[35], 1);
        check("p1_busy36", busy_log[36], 0);
        check("p1_phi_hold", phi_log[38], 32'h0300_0000);

        // nco_valid low for 20 cycles: RUN entered at c=21, full dwell kept
        cfg_last = 0; dwell = 4;
        run_pass(20, -1, 40);
        check("nv_first_c", first_c, 21);
        check("nv_n_samp", n_samp, 4);
        check("nv_done_c", done_c, 25);

        // stop during slot 1, then replay from slot 0
        cfg_last = 2; dwell = 4;
        run_pass(0, 15, 20);
        check("stop_idx15", idx_log[15], 1);
        check("stop_busy16", busy_log[16], 0);
        check("stop_idx16", idx_log[16], 0);
        check("stop_n_done", n_done, 0);
        run_pass(0, -1, 40);
        check("replay_phi0", phi_log[0], 32'h0100_0000);
        check("replay_n_samp", n_samp, 12);
        check("replay_done_c", done_c, 36);

        // Writes while busy and out of range are ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        wr(1, 32'hDEAD_BEEF);
        for (int k = 0; k < 60 && busy; k++) tick();
        check("wr_idle", busy, 0);
        wr(9, 32'hBAD0_BAD0);
        run_pass(0, -1, 40);
        check("wr_phi0", phi_log[0], 32'h0100_0000);
        check("wr_phi12", phi_log[12], 32'h0200_0000);
        check("wr_phi24", phi_log[24], 32'h0300_0000);

        // dwell=0 with a single slot: one sample then done
        cfg_last = 0; dwell = 0;
        run_pass(0, -1, 20);
        check("d0_n_samp", n_samp, 1);
        check("d0_done_c", done_c, 9);
        check("d0_n_done", n_done, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nco_hop_ctrl.md
Name: nco_hop_ctrl

Overview:
- Sequencer for the phase-accumulator NCO in the OFDM carrier path.
- Holds a small table of phase increments (one per subcarrier/hop slot) and steps the NCO through the slots in order.
- For each slot: drives the NCO phase increment, waits out the NCO pipeline latency, then qualifies a fixed number ("dwell") of valid output samples.
- Sits between the frame control logic (start/stop, configuration writes) and the NCO (phi_inc, clken, out_valid).

Parameters:
- apr, 32, phase increment / accumulator width
- nslots, 8, number of table entries
- slot_aw, 3, table address width (2^slot_aw >= nslots)
- dwr, 16, dwell counter width
- lat, 8, settle cycles after an increment change before samples are qualified (1..255)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  slot_aw  table write address
- cfg_data  in  apr  phase increment to write
- cfg_last  in  slot_aw  index of last slot in a pass; latched at start
- dwell  in  dwr  samples per slot; latched at start
- start  in  1  begin a pass (honoured in IDLE only)
- stop  in  1  abort; wins over every other event
- nco_valid  in  1  NCO out_valid
- phi_inc_o  out  apr  phase increment to the NCO
- nco_clken  out  1  NCO clock enable
- sample_en  out  1  current NCO sample belongs to the current slot
- slot_first  out  1  first qualified sample of a slot
- slot_idx  out  slot_aw  current slot
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset values (synchronous reset): state IDLE, phi_inc_o=0, slot_idx=0, busy=0, done=0. Table contents are not reset.
- Table writes:
  - cfg_we writes table[cfg_addr] in IDLE only; ignored while busy=1.
  - Writes with cfg_addr >= nslots are ignored.
- States: IDLE, SETTLE, RUN.
- nco_clken = busy (NCO frozen in IDLE).
- IDLE, start=1 (and stop=0), at the next edge:
  - latch cfg_last (clamped to nslots-1) and dwell (0 treated as 1)
  - phi_inc_o <= table[0]; slot_idx <= 0
  - settle counter <= lat-1; busy <= 1; go to SETTLE
- SETTLE:
  - Counter decrements every cycle, stopping at 0.
  - Leave for RUN when counter==0 and nco_valid=1; load dwell counter <= dwell-1.
  - If nco_valid stays 0, remain in SETTLE indefinitely.
- RUN:
  - sample_en = (state==RUN) & nco_valid (combinational).
  - slot_first = sample_en & first-sample flag; flag is set on entry to RUN and cleared by the first sample_en.
  - Dwell counter decrements on each sample_en.
- End of slot (sample_en with dwell counter==0):
  - If slot_idx != latched last: slot_idx+1, phi_inc_o <= table[slot_idx+1], settle counter <= lat-1, go to SETTLE.
  - Otherwise: go to IDLE, busy <= 0, done <= 1 for one cycle, phi_inc_o holds its value.
- Latency:
  - Start edge to first possible sample_en is lat+1 cycles (start edge, then lat SETTLE cycles, then RUN), given nco_valid=1 throughout.
  - Cycles per slot = lat + dwell.
- stop=1 in any state: next edge goes to IDLE, busy=0, no done pulse, slot_idx=0.
- start while busy is ignored. start and stop in the same cycle: stop wins.
- reset mid-pass behaves like stop, but also clears phi_inc_o.

Optional Feature:
- Macro: NCO_HOP_LOOP_EN.
- Defined:
  - At end of the last slot, wrap to slot 0 (phi_inc_o <= table[0], go to SETTLE).
  - done pulses once per completed pass; busy stays 1 until stop.
  - dwell and cfg_last stay latched from the original start.
- Undefined: single pass, as described in Behaviour.

Test Plan:
- Write table[0..2] = 0x0100_0000, 0x0200_0000, 0x0300_0000; cfg_last=2, dwell=4, lat=8, nco_valid=1, start -> phi_inc_o steps 0x01..,0x02..,0x03.. every 12 cycles; 12 sample_en total; slot_first at samples 1, 5, 9; done pulses once, 36 cycles after start; busy falls with done.
- nco_valid held 0 for 20 cycles after start -> no sample_en; RUN entered on the first cycle with nco_valid=1; dwell count unchanged.
- stop asserted during slot 1 of the above pass -> next cycle busy=0, slot_idx=0, no done pulse; a later start replays from slot 0.
- cfg_we to addr 1 while busy, and to addr 9 in IDLE -> table unchanged (read back via phi_inc_o on the next pass).
- dwell=0 with cfg_last=0 -> exactly one sample_en, then done.
- NCO_HOP_LOOP_EN defined, cfg_last=1, dwell=2 -> slot_idx sequence 0,1,0,1...; done every 20 cycles; busy stays 1 until stop.
